// File: rtl/foreground_line_renderer.sv
`default_nettype none
// ============================================================================
// Module   : foreground_line_renderer
// Purpose  : Sequential per-line foreground object renderer into a double-
//            buffered line store, with pixel readout by current_x.
// Revision : 1.0
// ============================================================================
module foreground_line_renderer #(
  parameter int NUM_OBJECTS  = 64,
  parameter int MAX_PER_LINE = 16,
  parameter int LINE_WIDTH   = 256,
  parameter int PMFA_WIDTH   = 5
) (
  input  logic                           gpu_clk,
  input  logic                           rst,
  input  logic                           line_start,
  input  logic [7:0]                     render_y,
  output logic [$clog2(NUM_OBJECTS)-1:0] obm_index,
  input  logic [31:0]                    obm_data,
  output logic [PMFA_WIDTH+2:0]          pmf_addr,
  input  logic [15:0]                    pmf_data,
  input  logic [8:0]                     current_x,
  output logic [1:0]                     r,
  output logic [1:0]                     g,
  output logic [1:0]                     b,
  output logic                           valid,
  output logic                           busy,
  output logic                           overflow,
  output logic                           late
);

  localparam int IDX_W  = $clog2(NUM_OBJECTS);
  localparam int ADDR_W = $clog2(LINE_WIDTH);
  localparam int HIT_W  = $clog2(MAX_PER_LINE + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OBJECTS - 1);
  localparam logic [8:0]       LINE_END  = 9'(LINE_WIDTH);
  localparam logic [HIT_W-1:0] HIT_LIMIT = HIT_W'(MAX_PER_LINE);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_SCAN_REQ = 3'd2;
  localparam logic [2:0] S_SCAN_CHK = 3'd3;
  localparam logic [2:0] S_FETCH    = 3'd4;
  localparam logic [2:0] S_DRAW     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             sel;
  logic             back_ready;
  logic             front_valid;
  logic             line_ovf;
  logic [7:0]       line_y;
  logic [IDX_W-1:0] idx;
  logic [HIT_W-1:0] hit_count;
  logic [8:0]       clr_k;
  logic [7:0]       obj_x;
  logic             obj_hflip;
  logic [2:0]       obj_color;
  logic [15:0]      pattern;
  logic [2:0]       k;

  logic [6:0] mem0 [LINE_WIDTH];
  logic [6:0] mem1 [LINE_WIDTH];

  logic [7:0]        obj_y;
  logic [7:0]        dy;
  logic              hit;
  logic [2:0]        row;
  logic [2:0]        fetch_row;
  logic [2:0]        pix;
  logic [1:0]        p;
  logic [8:0]        draw_x;
  logic              in_range;
  logic [ADDR_W-1:0] draw_addr;
  logic [6:0]        back_rd;
  logic [ADDR_W-1:0] rd_addr;
  logic [6:0]        front_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_data;
  logic              unused_obm;

  assign unused_obm = ^obm_data;

  // Row hit test uses 8-bit modular difference so objects wrap across line 0.
  assign obj_y     = obm_data[23:16];
  assign dy        = line_y - obj_y;
  assign hit       = (obj_y != 8'hFF) && (dy < 8'd8);
  assign row       = dy[2:0];
  assign fetch_row = obm_data[13] ? ~row : row;

  assign pix       = obj_hflip ? ~k : k;
  assign p         = pattern[{~pix, 1'b0} +: 2];
  assign draw_x    = {1'b0, obj_x} + {6'b0, k};
  assign in_range  = draw_x < LINE_END;
  assign draw_addr = draw_x[ADDR_W-1:0];
  assign back_rd   = sel ? mem0[draw_addr] : mem1[draw_addr];
  assign rd_addr   = current_x[ADDR_W-1:0];
  assign front_rd  = sel ? mem1[rd_addr] : mem0[rd_addr];

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_IDLE;
        S_CLEAR:    if (clr_k == LINE_END - 9'd1) state_nxt = S_SCAN_REQ;
        S_SCAN_REQ: state_nxt = S_SCAN_CHK;
        S_SCAN_CHK: begin
          if (hit) begin
            state_nxt = (hit_count == HIT_LIMIT) ? S_DONE : S_FETCH;
          end else begin
            state_nxt = (idx == LAST_IDX) ? S_DONE : S_SCAN_REQ;
          end
        end
        S_FETCH:    state_nxt = S_DRAW;
        S_DRAW:     if (k == 3'd7) state_nxt = (idx == LAST_IDX) ? S_DONE : S_SCAN_REQ;
        S_DONE:     state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Store writes are suppressed on line_start so a swap never lands a stray
  // pixel into the buffer that is about to become the displayed one.
  always_comb begin
    obm_index = idx;
    busy      = (state != S_IDLE);
    pmf_addr  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      S_CLEAR: begin
        wr_en   = !line_start;
        wr_addr = clr_k[ADDR_W-1:0];
      end
      S_SCAN_CHK: begin
        if (hit) pmf_addr = {obm_data[8 +: PMFA_WIDTH], fetch_row};
      end
      S_DRAW: begin
        wr_en   = !line_start && (p != 2'b00) && in_range && !back_rd[6];
        wr_addr = draw_addr;
        wr_data = {1'b1, {2{obj_color[2]}} & p, {2{obj_color[1]}} & p,
                   {2{obj_color[0]}} & p};
      end
      default: ;
    endcase
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      sel         <= 1'b0;
      back_ready  <= 1'b0;
      front_valid <= 1'b0;
      overflow    <= 1'b0;
      late        <= 1'b0;
      line_ovf    <= 1'b0;
      line_y      <= '0;
      idx         <= '0;
      hit_count   <= '0;
      clr_k       <= '0;
      obj_x       <= '0;
      obj_hflip   <= 1'b0;
      obj_color   <= '0;
      pattern     <= '0;
      k           <= '0;
    end else if (line_start) begin
      if (busy) late <= 1'b1;
      if (back_ready) begin
        sel         <= ~sel;
        front_valid <= 1'b1;
        overflow    <= line_ovf;
      end else begin
        front_valid <= 1'b0;
      end
      line_y     <= render_y;
      back_ready <= 1'b0;
      line_ovf   <= 1'b0;
      idx        <= '0;
      hit_count  <= '0;
      clr_k      <= '0;
    end else begin
      case (state)
        S_CLEAR: clr_k <= clr_k + 9'd1;
        S_SCAN_CHK: begin
          if (hit) begin
            if (hit_count == HIT_LIMIT) begin
              line_ovf <= 1'b1;
            end else begin
              hit_count <= hit_count + 1'b1;
              obj_x     <= obm_data[31:24];
              obj_hflip <= obm_data[14];
              obj_color <= obm_data[2:0];
            end
          end else if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        S_FETCH: begin
          pattern <= pmf_data;
          k       <= 3'd0;
        end
        S_DRAW: begin
          k <= k + 3'd1;
          if (k == 3'd7 && idx != LAST_IDX) idx <= idx + 1'b1;
        end
        S_DONE: back_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (wr_en) begin
      if (sel) mem0[wr_addr] <= wr_data;
      else     mem1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      {valid, r, g, b} <= '0;
    end else if (front_valid && (current_x < LINE_END)) begin
      {valid, r, g, b} <= front_rd;
    end else begin
      {valid, r, g, b} <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_foreground_line_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_foreground_line_renderer
// Purpose  : Directed plus randomized checks of foreground_line_renderer
//            against a per-object painting reference model.
// Revision : 1.0
// ============================================================================
module tb_foreground_line_renderer;

  localparam int NOBJ = 64;
  localparam int MAXL = 16;
  localparam int LW   = 256;

  logic        gpu_clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [7:0]  render_y;
  logic [5:0]  obm_index;
  logic [31:0] obm_data;
  logic [7:0]  pmf_addr;
  logic [15:0] pmf_data;
  logic [8:0]  current_x;
  logic [1:0]  r, g, b;
  logic        valid, busy, overflow, late;

  logic [31:0] obm_mem [NOBJ];
  logic [15:0] pmf_mem [256];
  logic [7:0]  last_pmf;
  logic [6:0]  exp_line [LW];
  logic        exp_ovf;
  int          checks = 0;
  int          fails  = 0;

  foreground_line_renderer dut (
    .gpu_clk(gpu_clk), .rst(rst), .line_start(line_start), .render_y(render_y),
    .obm_index(obm_index), .obm_data(obm_data), .pmf_addr(pmf_addr),
    .pmf_data(pmf_data), .current_x(current_x), .r(r), .g(g), .b(b),
    .valid(valid), .busy(busy), .overflow(overflow), .late(late)
  );

  always #5 gpu_clk = ~gpu_clk;

  // Synchronous-read object and pattern memories.
  always @(posedge gpu_clk) begin
    obm_data <= obm_mem[obm_index];
    pmf_data <= pmf_mem[pmf_addr];
    if (pmf_addr != 8'd0) last_pmf <= pmf_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] x, input logic [7:0] y,
                                     input logic hf, input logic vf,
                                     input logic [4:0] pa, input logic [2:0] c);
    return {x, y, 1'b0, hf, vf, pa, 5'b0, c};
  endfunction

  task automatic hide_all();
    for (int i = 0; i < NOBJ; i++) obm_mem[i] = mk(8'($urandom), 8'hFF, 1'b0, 1'b0, 5'd0, 3'd7);
  endtask

  // Paint objects in index order; an opaque pixel is never overwritten.
  task automatic model(input logic [7:0] ry);
    int hits;
    hits = 0;
    exp_ovf = 1'b0;
    for (int x = 0; x < LW; x++) exp_line[x] = 7'd0;
    for (int i = 0; i < NOBJ; i++) begin
      logic [7:0]  oy, dy;
      logic [2:0]  rs, c;
      logic [15:0] pat;
      logic [1:0]  p;
      int          pix, px;
      oy = obm_mem[i][23:16];
      dy = ry - oy;
      if (oy == 8'hFF || dy >= 8'd8) continue;
      if (hits == MAXL) begin
        exp_ovf = 1'b1;
        break;
      end
      hits++;
      rs  = obm_mem[i][13] ? 3'(7 - int'(dy)) : dy[2:0];
      pat = pmf_mem[{obm_mem[i][12:8], rs}];
      c   = obm_mem[i][2:0];
      for (int kk = 0; kk < 8; kk++) begin
        pix = obm_mem[i][14] ? 7 - kk : kk;
        px  = int'(obm_mem[i][31:24]) + kk;
        p   = pat[15 - 2*pix -: 2];
        if (p != 2'b00 && px < LW && !exp_line[px][6])
          exp_line[px] = {1'b1, c[2] ? p : 2'b00, c[1] ? p : 2'b00, c[0] ? p : 2'b00};
      end
    end
  endtask

  task automatic pulse(input logic [7:0] ry);
    render_y   = ry;
    line_start = 1'b1;
    @(posedge gpu_clk); #1;
    line_start = 1'b0;
  endtask

  task automatic run_line(input logic [7:0] ry);
    int c;
    pulse(ry);
    c = 0;
    while (busy && c < 2000) begin
      @(posedge gpu_clk); #1;
      c++;
    end
    chk("render_done_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic read_px(input int x, output logic [6:0] v);
    current_x = 9'(x);
    @(posedge gpu_clk); #1;
    v = {valid, r, g, b};
  endtask

  task automatic check_front(input string tag);
    logic [6:0] v;
    chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
    chk({tag, "_late"}, {31'b0, late}, 32'd0);
    for (int x = 0; x < LW + 4; x++) begin
      read_px(x, v);
      chk($sformatf("%s_x%0d", tag, x), {25'b0, v}, (x < LW) ? {25'b0, exp_line[x]} : 32'd0);
    end
  endtask

  task automatic do_test(input string tag, input logic [7:0] ry);
    model(ry);
    run_line(ry);
    run_line(ry);
    check_front(tag);
  endtask

  initial begin
    logic [6:0] v;
    logic [7:0] ry;
    rst = 1'b1; line_start = 1'b0; render_y = 8'd0; current_x = 9'd0;
    for (int i = 0; i < 256; i++) pmf_mem[i] = 16'($urandom);
    hide_all();
    repeat (3) @(posedge gpu_clk);
    #1 rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_pixel", {25'b0, valid, r, g, b}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_late", {31'b0, late}, 32'd0);
    chk("reset_obm_index", {26'b0, obm_index}, 32'd0);
    chk("reset_pmf_addr", {24'b0, pmf_addr}, 32'd0);

    // Single object, uniform 0x5555 pattern.
    for (int i = 8; i < 16; i++) pmf_mem[i] = 16'h5555;
    obm_mem[0] = mk(8'd10, 8'd20, 1'b0, 1'b0, 5'd1, 3'b111);
    do_test("t1", 8'd23);
    read_px(10, v); chk("t1_x10_const", {25'b0, v}, 32'h55);
    read_px(17, v); chk("t1_x17_const", {25'b0, v}, 32'h55);
    read_px(9, v);  chk("t1_x9_const", {25'b0, v}, 32'd0);
    read_px(18, v); chk("t1_x18_const", {25'b0, v}, 32'd0);

    // Two overlapping objects: lower index has priority.
    hide_all();
    obm_mem[0] = mk(8'd40, 8'd0, 1'b0, 1'b0, 5'd2, 3'b100);
    obm_mem[1] = mk(8'd40, 8'd0, 1'b0, 1'b0, 5'd3, 3'b011);
    do_test("t2", 8'd0);

    // Horizontal flip then vertical flip (vflip object last so its fetch is recorded).
    hide_all();
    pmf_mem[{5'd6, 3'd0}] = 16'hC000;
    obm_mem[0] = mk(8'd100, 8'd50, 1'b1, 1'b0, 5'd6, 3'b111);
    obm_mem[1] = mk(8'd20, 8'd50, 1'b0, 1'b1, 5'd5, 3'b010);
    do_test("t3", 8'd50);
    read_px(107, v); chk("t3_hflip_x107", {25'b0, v}, 32'h7F);
    read_px(100, v); chk("t3_hflip_x100", {25'b0, v}, 32'd0);
    chk("t3_vflip_pmf_addr", {24'b0, last_pmf}, 32'h2F);

    // 20 hits on one line, then a line with 2 hits.
    hide_all();
    for (int i = 0; i < 20; i++)
      obm_mem[i] = mk(8'($urandom), 8'(5 - $urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                      5'($urandom), 3'($urandom_range(1, 7)));
    do_test("t4_full", 8'd5);
    chk("t4_overflow_set", {31'b0, overflow}, 32'd1);
    hide_all();
    obm_mem[3] = mk(8'd30, 8'd100, 1'b0, 1'b0, 5'd7, 3'b101);
    obm_mem[9] = mk(8'd34, 8'd97, 1'b1, 1'b0, 5'd8, 3'b110);
    do_test("t4_two", 8'd100);
    chk("t4_overflow_clear", {31'b0, overflow}, 32'd0);

    // Right-edge clip, hidden object, wrapped y.
    hide_all();
    for (int i = 0; i < 8; i++) pmf_mem[{5'd9, 3'(i)}] = 16'hFFFF;
    obm_mem[0] = mk(8'd252, 8'd1, 1'b0, 1'b0, 5'd9, 3'b111);
    obm_mem[1] = mk(8'd100, 8'hFF, 1'b0, 1'b0, 5'd9, 3'b111);
    obm_mem[2] = mk(8'd60, 8'd254, 1'b0, 1'b0, 5'd10, 3'b011);
    do_test("t5", 8'd1);
    read_px(255, v); chk("t5_x255_const", {25'b0, v}, 32'h7F);
    read_px(0, v);   chk("t5_x0_nowrap", {25'b0, v}, 32'd0);
    read_px(100, v); chk("t5_hidden_x100", {25'b0, v}, 32'd0);

    // Randomized object tables.
    for (int t = 0; t < 4; t++) begin
      ry = 8'($urandom);
      hide_all();
      for (int i = 0; i < NOBJ; i++)
        if ($urandom_range(0, 1) == 1)
          obm_mem[i] = mk(8'($urandom), 8'(int'(ry) - int'($urandom_range(0, 11))),
                          1'($urandom), 1'($urandom), 5'($urandom), 3'($urandom_range(1, 7)));
      do_test($sformatf("rand%0d", t), ry);
    end

    // Late line_start aborts the render; no swap, display blanked.
    pulse(8'd7);
    repeat (100) @(posedge gpu_clk);
    #1;
    pulse(8'd8);
    chk("t6_late", {31'b0, late}, 32'd1);
    chk("t6_busy", {31'b0, busy}, 32'd1);
    for (int x = 0; x < 16; x++) begin
      read_px(x * 16, v);
      chk($sformatf("t6_blank_x%0d", x * 16), {25'b0, v}, 32'd0);
    end
    chk("t6_late_sticky", {31'b0, late}, 32'd1);
    rst = 1'b1;
    @(posedge gpu_clk); #1;
    chk("t6_rst_late", {31'b0, late}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
